// File: rtl/key_debounce.sv
// key_debounce: per-channel synchronized key debouncer with press, release and long-press pulses.
module key_debounce #(
    parameter int unsigned DEB_CNT     = 1_000_000,
    parameter int unsigned LONG_CNT    = 50_000_000,
    parameter int unsigned KEY_NUM     = 1,
    parameter bit          KEY_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);
    localparam logic [31:0] DEB_M1  = 32'(DEB_CNT - 1);
    localparam logic [31:0] LONG_M1 = 32'(LONG_CNT - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_e;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
        logic        sync1_q, sync2_q, act;
        state_e      state_q, state_d;
        logic [31:0] cnt_q, cnt_d;
        logic        long_done_q, long_done_d;
        logic        state_out_q, state_out_d;
        logic        press_q, press_d, release_q, release_d, long_q, long_d;

        assign act = sync2_q ^ KEY_ACT_LOW;

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            long_done_d = long_done_q;
            state_out_d = state_out_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (act) state_d = PRESS_DB;
                end
                PRESS_DB: begin
                    if (!act) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_M1) begin
                        state_d     = PRESSED;
                        cnt_d       = '0;
                        state_out_d = 1'b1;
                        press_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                PRESSED: begin
                    if (cnt_q == LONG_M1 && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                    if (!act) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end else if (cnt_q != LONG_M1) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                RELEASE_DB: begin
                    // A bounce back into PRESSED must not re-arm the long-press event.
                    if (act) begin
                        state_d = PRESSED;
                        cnt_d   = long_done_q ? LONG_M1 : '0;
                    end else if (cnt_q == DEB_M1) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        state_out_d = 1'b0;
                        release_d   = 1'b1;
                        long_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q     <= KEY_ACT_LOW;
                sync2_q     <= KEY_ACT_LOW;
                state_q     <= IDLE;
                cnt_q       <= '0;
                long_done_q <= 1'b0;
                state_out_q <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                sync1_q     <= key_in[k];
                sync2_q     <= sync1_q;
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                long_done_q <= long_done_d;
                state_out_q <= state_out_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
            end
        end

        assign key_state[k]   = state_out_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEB_CNT, default 1_000_000: debounce window in clk cycles (20 ms at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter LONG_CNT, default 50_000_000: hold time in clk cycles, counted from entry into PRESSED, for the long-press event; legal range DEB_CNT+1..2^32-1.
REQ-003 SHALL have parameter KEY_NUM, default 1: number of independent key channels.
REQ-004 SHALL have parameter KEY_ACT_LOW, default 1: 1 means a key is pressed when key_in is 0; 0 means pressed when key_in is 1.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 key_in  input  KEY_NUM  raw asynchronous key pins, with bounce.
REQ-008 key_state  output  KEY_NUM  debounced level; 1 = pressed, in active-high sense regardless of KEY_ACT_LOW.
REQ-009 key_press  output  KEY_NUM  one-cycle pulse on each debounced press.
REQ-010 key_release  output  KEY_NUM  one-cycle pulse on each debounced release.
REQ-011 key_long  output  KEY_NUM  one-cycle pulse, at most once per press, when the hold reaches LONG_CNT.

Function
REQ-012 Each channel SHALL be fully independent: own synchronizer, FSM, 32-bit counter and long-done flag.
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer; act = sync2 XOR KEY_ACT_LOW.
REQ-014 The FSM SHALL have 4 states: IDLE, PRESS_DB, PRESSED, RELEASE_DB.
REQ-015 IDLE: on act=1, go to PRESS_DB with cnt=0; otherwise stay, with cnt=0.
REQ-016 PRESS_DB: on act=0, return to IDLE with no output event.
REQ-017 PRESS_DB: otherwise cnt increments; when cnt=DEB_CNT-1, go to PRESSED with cnt=0, set key_state=1, pulse key_press.
REQ-018 PRESSED: on act=0, go to RELEASE_DB with cnt=0.
REQ-019 PRESSED: otherwise cnt increments, saturating at LONG_CNT-1.
REQ-020 PRESSED: on the cycle cnt=LONG_CNT-1 and long_done=0, pulse key_long and set long_done=1.
REQ-021 RELEASE_DB: on act=1, return to PRESSED with cnt=LONG_CNT-1 if long_done=1, else cnt=0; no event in either case.
REQ-022 RELEASE_DB: otherwise cnt increments; when cnt=DEB_CNT-1, go to IDLE with cnt=0, set key_state=0, pulse key_release, clear long_done.
REQ-023 All outputs SHALL be registered.
REQ-024 Press latency: with edge 1 being the first clk edge sampling the new stable key_in level, key_press and key_state rise after edge DEB_CNT+3.
REQ-025 Release latency SHALL be identical in form to press latency.
REQ-026 A bounce lasting fewer than DEB_CNT consecutive stable act cycles SHALL produce no event and no change of key_state.
REQ-027 key_press and key_release SHALL strictly alternate per channel, starting with key_press after reset.
REQ-028 key_long SHALL occur only between a key_press and the following key_release.
REQ-029 Multiple channels MAY pulse in the same cycle; no arbitration between channels.

Reset
REQ-030 While rst=1: synchronizer flops = KEY_ACT_LOW (inactive level); FSM=IDLE; cnt=0; long_done=0; key_state, key_press, key_release, key_long = 0.
REQ-031 Releasing rst with a key already held SHALL yield key_press after the normal REQ-024 latency; no spurious release.
REQ-032 Asserting rst mid-press or mid-debounce SHALL immediately force all outputs to 0; no release pulse is emitted.

Verification (DEB_CNT=4, LONG_CNT=10, KEY_NUM=2, KEY_ACT_LOW=1)
REQ-033 key_in[0] 1->0 held -> key_press[0]=1 for exactly one cycle after edge 7; key_state[0]=1 from then on; channel 1 stays quiet.
REQ-034 key_in[0] low for 3 cycles then high (glitch) -> no key_press, key_state stays 0.
REQ-035 Press held 30 cycles -> exactly one key_long[0], 10 cycles after key_press; release -> key_release after 7 edges; no second key_long.
REQ-036 While PRESSED, a 2-cycle release bounce -> no key_release; continued hold -> no extra key_press or key_long.
REQ-037 Both keys pressed in the same cycle -> key_press = 2'b11 in one cycle; rst asserted mid-hold -> all outputs 0 at once and no key_release afterwards.
